// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU pushes bytes into a small FIFO,
// a shift FSM serialises them; STATUS/DIV are readable with one cycle of latency.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter logic [15:0] DIV_RESET = 16'd434,
    parameter int          FIFO_AW   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_req_i,
    input  logic [31:0] mem_rd_addr_i,
    output logic [31:0] mem_rd_data_o,
    input  logic        mem_wr_req_i,
    input  logic [3:0]  mem_wr_sel_i,
    input  logic [31:0] mem_wr_addr_i,
    input  logic [31:0] mem_wr_data_i,
    output logic        uart_tx_o,
    output logic        tx_empty_o
);
    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q;
    logic [7:0]         shift_q;
    logic [2:0]         bit_cnt_q;
    logic [15:0]        baud_q;
    logic               tx_q;
    logic [15:0]        div_q;
    logic               ovf_q;
    logic [31:0]        rd_data_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]         fifo_mem [DEPTH];

    logic        wr_hit, rd_hit, push_req, push, pop, ovf_clr;
    logic        fifo_full, fifo_empty, busy, bit_end;
    logic [15:0] div_m1;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign unused_bits = ^{mem_rd_addr_i[11:4], mem_rd_addr_i[1:0],
                           mem_wr_addr_i[11:4], mem_wr_addr_i[1:0], mem_wr_data_i[31:16]};

    assign wr_hit   = mem_wr_req_i && (mem_wr_addr_i[31:12] == BASE_ADDR[31:12]);
    assign rd_hit   = mem_rd_addr_i[31:12] == BASE_ADDR[31:12];
    assign push_req = wr_hit && (mem_wr_addr_i[3:2] == 2'd0) && mem_wr_sel_i[0];
    assign ovf_clr  = wr_hit && (mem_wr_addr_i[3:2] == 2'd1) && mem_wr_sel_i[0] && mem_wr_data_i[3];

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign busy       = (state_q != IDLE);
    assign push       = push_req && !fifo_full;
    assign bit_end    = (baud_q == 16'd0);
    // The FSM pops from IDLE, or at the end of a stop bit so frames run back to back.
    assign pop        = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    assign div_m1     = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;

    assign uart_tx_o     = tx_q;
    assign tx_empty_o    = fifo_empty && !busy;
    assign mem_rd_data_o = rd_data_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
    end

    always_comb begin
        rd_val = 32'd0;
        if (rd_hit) begin
            case (mem_rd_addr_i[3:2])
                2'd1:    rd_val = {{(28 - (FIFO_AW + 1)){1'b0}}, count_q, ovf_q, busy, fifo_empty, fifo_full};
                2'd2:    rd_val = {16'd0, div_q};
                default: rd_val = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= mem_wr_data_i[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            div_q     <= DIV_RESET;
            rd_data_q <= 32'd0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push_req && fifo_full) ovf_q <= 1'b1;
            else if (ovf_clr)          ovf_q <= 1'b0;
            if (wr_hit && (mem_wr_addr_i[3:2] == 2'd2)) begin
                if (mem_wr_sel_i[0]) div_q[7:0]  <= mem_wr_data_i[7:0];
                if (mem_wr_sel_i[1]) div_q[15:8] <= mem_wr_data_i[15:8];
            end
            if (mem_rd_req_i) rd_data_q <= rd_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
            baud_q    <= 16'd0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= fifo_mem[rd_ptr_q];
                        baud_q  <= div_m1;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_q    <= div_m1;
                        bit_cnt_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q <= div_m1;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift_q <= fifo_mem[rd_ptr_q];
                            baud_q  <= div_m1;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboarded bench for uart_tx_mmio: a timing-level model predicts frame start
// edges, FIFO occupancy and register reads; monitors compare line and read data.
module tb_uart_tx_mmio;
    localparam logic [31:0] A_TX  = 32'h4000_0000;
    localparam logic [31:0] A_ST  = 32'h4000_0004;
    localparam logic [31:0] A_DIV = 32'h4000_0008;
    localparam logic [31:0] A_RSV = 32'h4000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_rd_req_i = 1'b0;
    logic [31:0] mem_rd_addr_i = '0;
    logic [31:0] mem_rd_data_o;
    logic        mem_wr_req_i = 1'b0;
    logic [3:0]  mem_wr_sel_i = '0;
    logic [31:0] mem_wr_addr_i = '0;
    logic [31:0] mem_wr_data_i = '0;
    logic        uart_tx_o;
    logic        tx_empty_o;

    uart_tx_mmio dut (
        .clk(clk), .rst(rst),
        .mem_rd_req_i(mem_rd_req_i), .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_data_o(mem_rd_data_o),
        .mem_wr_req_i(mem_wr_req_i), .mem_wr_sel_i(mem_wr_sel_i), .mem_wr_addr_i(mem_wr_addr_i),
        .mem_wr_data_i(mem_wr_data_i), .uart_tx_o(uart_tx_o), .tx_empty_o(tx_empty_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: every accepted byte is a frame with a pop edge and a duration.
    typedef struct { int wedge; int start; int d; } sched_t;
    typedef struct { logic [7:0] b; int start; int d; } fexp_t;
    sched_t      sched[$];
    fexp_t       fexp_q[$];
    logic [31:0] rexp_q[$];
    int          free_at = 0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_div = 16'd434;

    function automatic int m_dive();
        return (m_div == 16'd0) ? 1 : int'(m_div);
    endfunction

    function automatic int m_count(int e);
        int n = 0;
        foreach (sched[i]) if (sched[i].wedge < e && sched[i].start >= e) n++;
        return n;
    endfunction

    function automatic bit m_busy(int e);
        foreach (sched[i]) if (sched[i].start < e && e <= sched[i].start + 10 * sched[i].d) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] a, int e);
        int c;
        logic [3:0] c4;
        if (a[31:12] != 20'h40000) return 32'd0;
        c  = m_count(e);
        c4 = c[3:0];
        case (a[3:2])
            2'd1:    return {24'd0, c4, m_ovf, m_busy(e), c == 0, c == 8};
            2'd2:    return {16'd0, m_div};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void m_write(logic [31:0] a, logic [31:0] wd, logic [3:0] sel, int e);
        sched_t s;
        fexp_t  f;
        if (a[31:12] != 20'h40000) return;
        case (a[3:2])
            2'd0: if (sel[0]) begin
                if (m_count(e) == 8) m_ovf = 1'b1;
                else begin
                    s.wedge = e;
                    s.start = (e < free_at) ? free_at : e + 1;
                    s.d     = m_dive();
                    f.b = wd[7:0]; f.start = s.start; f.d = s.d;
                    sched.push_back(s);
                    fexp_q.push_back(f);
                    free_at = s.start + 10 * s.d;
                end
            end
            2'd1: if (sel[0] && wd[3]) m_ovf = 1'b0;
            2'd2: begin
                if (sel[0]) m_div[7:0]  = wd[7:0];
                if (sel[1]) m_div[15:8] = wd[15:8];
            end
            default: ;
        endcase
    endfunction

    function automatic void m_reset();
        sched.delete();
        fexp_q.delete();
        free_at = 0;
        m_ovf   = 1'b0;
        m_div   = 16'd434;
    endfunction

    // One bus cycle; a read in the same cycle as a write sees the pre-write model state.
    task automatic bus_op(bit rd, logic [31:0] ra, bit wr, logic [31:0] wa, logic [31:0] wd, logic [3:0] sel);
        int e;
        @(negedge clk);
        e = cyc + 1;
        mem_rd_req_i = rd; mem_rd_addr_i = ra;
        mem_wr_req_i = wr; mem_wr_addr_i = wa; mem_wr_data_i = wd; mem_wr_sel_i = sel;
        if (rd) rexp_q.push_back(m_read(ra, e));
        if (wr) m_write(wa, wd, sel, e);
        @(posedge clk);
        #1;
        mem_rd_req_i = 1'b0;
        mem_wr_req_i = 1'b0;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] sel);
        bus_op(1'b0, '0, 1'b1, a, d, sel);
    endtask

    task automatic rd(logic [31:0] a);
        bus_op(1'b1, a, 1'b0, '0, '0, '0);
    endtask

    task automatic drain();
        int n;
        n = free_at - cyc + 3;
        if (n < 1) n = 1;
        repeat (n) @(negedge clk);
    endtask

    // Read-data monitor
    logic rd_seen = 1'b0;
    always @(posedge clk) rd_seen <= mem_rd_req_i && rst;
    always @(negedge clk) begin
        if (rd_seen) begin
            if (rexp_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
            else check("rd_data", mem_rd_data_o, rexp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst) check("tx_empty", {31'd0, tx_empty_o}, {31'd0, m_count(cyc + 1) == 0 && !m_busy(cyc + 1)});
    end

    // Line monitor: decodes each frame and compares start edge and every bit sample.
    initial begin
        fexp_t f;
        int    errs;
        int    bi;
        logic  lvl;
        forever begin
            @(negedge clk);
            if (rst && uart_tx_o === 1'b0) begin
                if (fexp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    for (int k = 0; k < 20000 && uart_tx_o === 1'b0; k++) @(negedge clk);
                end else begin
                    f = fexp_q.pop_front();
                    check($sformatf("frame_start_%02h", f.b), cyc, f.start);
                    errs = 0;
                    for (int i = 0; i < 10 * f.d; i++) begin
                        if (i > 0) @(negedge clk);
                        if (!rst) break;
                        bi  = i / f.d;
                        lvl = (bi == 0) ? 1'b0 : (bi <= 8) ? f.b[bi-1] : 1'b1;
                        if (uart_tx_o !== lvl) errs++;
                    end
                    check($sformatf("frame_bits_%02h", f.b), errs, 0);
                    $display("frame 0x%02h start=%0d div=%0d bit_errors=%0d", f.b, f.start, f.d, errs);
                end
            end
        end
    end

    initial begin
        int r;
        int s6;
        m_reset();
        // T1: reset state
        repeat (3) @(negedge clk);
        check("rst_line", {31'd0, uart_tx_o}, 32'd1);
        check("rst_empty", {31'd0, tx_empty_o}, 32'd1);
        check("rst_rdata", mem_rd_data_o, 32'd0);
        rst = 1'b1;
        rd(A_ST);
        rd(A_DIV);
        bus_op(1'b1, A_RSV, 1'b0, '0, '0, '0);

        // T2: single frame at DIV=4
        wr(A_DIV, 32'd4, 4'b0011);
        wr(A_TX, 32'hA5, 4'b0001);
        repeat (10) @(negedge clk);
        rd(A_ST);
        drain();

        // DIV=0 behaves as 1
        wr(A_DIV, 32'd0, 4'b0011);
        rd(A_DIV);
        wr(A_TX, 32'h3C, 4'b0001);
        drain();

        // T3: overflow at DIV=100
        wr(A_DIV, 32'd100, 4'b0011);
        for (int i = 0; i < 10; i++) wr(A_TX, 32'h10 + i, 4'b0001);
        rd(A_ST);
        bus_op(1'b1, A_ST, 1'b1, A_ST, 32'h8, 4'b0001);
        rd(A_ST);
        drain();

        // T4: back-to-back frames at DIV=2
        wr(A_DIV, 32'd2, 4'b0011);
        wr(A_TX, 32'h00, 4'b0001);
        wr(A_TX, 32'hFF, 4'b0001);
        drain();

        // T5: byte selects, same-cycle read/write, out-of-range decode
        wr(A_TX, 32'h77, 4'b0010);
        wr(A_DIV, 32'h1234, 4'b0001);
        bus_op(1'b1, A_DIV, 1'b1, A_DIV, 32'h0500, 4'b0010);
        rd(A_DIV);
        wr(32'h4000_1000, 32'h55, 4'b1111);
        rd(32'h5000_0008);
        rd(A_ST);
        drain();

        // Randomised traffic with small dividers
        for (int rnd = 0; rnd < 3; rnd++) begin
            wr(A_DIV, $urandom_range(1, 3), 4'b0011);
            for (int it = 0; it < 250; it++) begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1, 2, 3: wr(A_TX, $urandom, 4'($urandom_range(0, 15)));
                    4, 5:       rd(A_ST);
                    6:          rd(($urandom_range(0, 1) == 1) ? A_DIV : A_RSV);
                    7:          wr(A_ST, $urandom, 4'($urandom_range(0, 15)));
                    8:          bus_op(1'b1, A_ST, 1'b1, A_TX, $urandom, 4'b0001);
                    default:    @(negedge clk);
                endcase
            end
            drain();
        end

        // T6: reset during data bit 3
        wr(A_DIV, 32'd4, 4'b0011);
        wr(A_TX, 32'h05, 4'b0001);
        s6 = sched[sched.size() - 1].start;
        while (cyc < s6 + 4 * 4 + 1) @(negedge clk);
        rst = 1'b0;
        m_reset();
        #1;
        check("t6_line_high", {31'd0, uart_tx_o}, 32'd1);
        check("t6_empty", {31'd0, tx_empty_o}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rd(A_ST);
        repeat (80) @(negedge clk);

        check("frames_outstanding", fexp_q.size(), 32'd0);
        check("reads_outstanding", rexp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
